mips_fetch: RTL and testbench

MIPS_FETCH -- requirements
Module: mips_fetch

---
 rtl/mips_fetch_if.sv | 30 +++
 rtl/mips_fetch.sv | 70 +++++++
 tb/tb_mips_fetch.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mips_fetch_if.sv
// Fetch-stage bus: instruction-memory request/ack plus the decode-side
// instruction handoff and branch/jump redirect inputs.
interface mips_fetch_if;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic        mem_ack_in;
    logic [31:0] mem_data_in;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        stall_in;
    logic        branch_taken_in;
    logic [15:0] imm16_in;
    logic        jump_in;
    logic [25:0] target_in;
    logic        jr_in;
    logic [31:0] jr_addr_in;

    modport master (
        output mem_req_out, mem_addr_out, instruction_out, pc_out, valid_out,
        input  mem_ack_in, mem_data_in, stall_in, branch_taken_in, imm16_in,
               jump_in, target_in, jr_in, jr_addr_in
    );

    modport slave (
        input  mem_req_out, mem_addr_out, instruction_out, pc_out, valid_out,
        output mem_ack_in, mem_data_in, stall_in, branch_taken_in, imm16_in,
               jump_in, target_in, jr_in, jr_addr_in
    );
endinterface

// File: rtl/mips_fetch.sv
// MIPS instruction fetch stage: IDLE -> REQ -> HOLD loop with one outstanding
// memory request and next-PC selection (JR > J > branch > sequential).
module mips_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    mips_fetch_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] pc_plus4;
    logic [31:0] branch_off;
    logic        consume;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            instr_reg <= 32'h0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = REQ;
            REQ:     if (bus.mem_ack_in) state_next = HOLD;
            HOLD:    if (!bus.stall_in)  state_next = REQ;
            default: state_next = IDLE;
        endcase
    end

    assign consume    = (state_reg == HOLD) && !bus.stall_in;
    assign pc_plus4   = pc_reg + 32'd4;
    assign branch_off = {{14{bus.imm16_in[15]}}, bus.imm16_in, 2'b00};

    // Redirects only matter on the consume edge; everywhere else the PC holds.
    always_comb begin
        pc_next    = pc_reg;
        instr_next = instr_reg;
        if (state_reg == REQ && bus.mem_ack_in)
            instr_next = bus.mem_data_in;
        if (consume) begin
            if (bus.jr_in)
                pc_next = bus.jr_addr_in & 32'hFFFF_FFFC;
            else if (bus.jump_in)
                pc_next = {pc_plus4[31:28], bus.target_in, 2'b00};
            else if (bus.branch_taken_in)
                pc_next = pc_plus4 + branch_off;
            else
                pc_next = pc_plus4;
        end
    end

    always_comb begin
        bus.mem_req_out     = (state_reg == REQ);
        bus.valid_out       = (state_reg == HOLD);
        bus.mem_addr_out    = pc_reg;
        bus.pc_out          = pc_reg;
        bus.instruction_out = instr_reg;
    end
endmodule

// File: tb/tb_mips_fetch.sv
// Directed bench for mips_fetch: reset, handshake timing, stall hold,
// next-PC priority and wrap, reset abandoning an in-flight request.
module tb_mips_fetch;
    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    mips_fetch_if bus ();

    mips_fetch #(.RESET_PC(32'h0040_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_redirects();
        bus.branch_taken_in = 1'b0;
        bus.imm16_in        = 16'h0;
        bus.jump_in         = 1'b0;
        bus.target_in       = 26'h0;
        bus.jr_in           = 1'b0;
        bus.jr_addr_in      = 32'h0;
    endtask

    // From REQ: ack with data, land in HOLD, then consume with current redirects.
    task automatic fetch_and_hold(input logic [31:0] data);
        bus.mem_ack_in  = 1'b1;
        bus.mem_data_in = data;
        bus.stall_in    = 1'b1;
        step();
        bus.mem_ack_in  = 1'b0;
        chk("hold_valid", {31'h0, bus.valid_out}, 32'h1);
        chk("hold_instr", bus.instruction_out, data);
        bus.stall_in    = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        bus.mem_ack_in  = 1'b0;
        bus.mem_data_in = 32'h0;
        bus.stall_in    = 1'b0;
        clear_redirects();
        step();
        step();
        chk("rst_req",   {31'h0, bus.mem_req_out}, 32'h0);
        chk("rst_valid", {31'h0, bus.valid_out}, 32'h0);
        chk("rst_pc",    bus.pc_out, 32'h0040_0000);
        chk("rst_instr", bus.instruction_out, 32'h0);

        // Zero-wait fetch
        reset = 1'b0;
        step();
        chk("first_req",  {31'h0, bus.mem_req_out}, 32'h1);
        chk("first_addr", bus.mem_addr_out, 32'h0040_0000);
        chk("first_valid", {31'h0, bus.valid_out}, 32'h0);
        bus.mem_ack_in  = 1'b1;
        bus.mem_data_in = 32'h2008_0005;
        step();
        bus.mem_ack_in  = 1'b0;
        chk("zw_valid", {31'h0, bus.valid_out}, 32'h1);
        chk("zw_instr", bus.instruction_out, 32'h2008_0005);
        chk("zw_noreq", {31'h0, bus.mem_req_out}, 32'h0);
        chk("zw_pc",    bus.pc_out, 32'h0040_0000);
        step();
        chk("seq_pc",    bus.pc_out, 32'h0040_0004);
        chk("seq_valid", {31'h0, bus.valid_out}, 32'h0);
        chk("seq_req",   {31'h0, bus.mem_req_out}, 32'h1);

        // Delayed ack: address stable for 3 cycles
        chk("wait_addr0", bus.mem_addr_out, 32'h0040_0004);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("wait_req",  {31'h0, bus.mem_req_out}, 32'h1);
            chk("wait_addr", bus.mem_addr_out, 32'h0040_0004);
        end
        bus.mem_ack_in  = 1'b1;
        bus.mem_data_in = 32'h8C09_0010;
        bus.stall_in    = 1'b1;
        step();
        // Stall with stray ack and redirects that must be ignored
        bus.mem_data_in = 32'hDEAD_BEEF;
        bus.jr_in       = 1'b1;
        bus.jr_addr_in  = 32'h1234_5678;
        bus.jump_in     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", {31'h0, bus.valid_out}, 32'h1);
            chk("stall_instr", bus.instruction_out, 32'h8C09_0010);
            chk("stall_pc",    bus.pc_out, 32'h0040_0004);
            chk("stall_noreq", {31'h0, bus.mem_req_out}, 32'h0);
            step();
        end
        bus.mem_ack_in = 1'b0;
        clear_redirects();
        bus.stall_in   = 1'b0;
        step();
        chk("post_stall_pc", bus.pc_out, 32'h0040_0008);

        // Backward branch
        fetch_and_hold(32'h1000_FFFC);
        bus.branch_taken_in = 1'b1;
        bus.imm16_in        = 16'hFFFC;
        step();
        clear_redirects();
        chk("branch_back_pc", bus.pc_out, 32'h003F_FFFC);

        // Forward branch
        fetch_and_hold(32'h1000_0003);
        bus.branch_taken_in = 1'b1;
        bus.imm16_in        = 16'h0003;
        step();
        clear_redirects();
        chk("branch_fwd_pc", bus.pc_out, 32'h0040_000C);

        // JR low bits masked
        fetch_and_hold(32'h0120_0008);
        bus.jr_in      = 1'b1;
        bus.jr_addr_in = 32'h0040_0013;
        step();
        clear_redirects();
        chk("jr_mask_pc", bus.pc_out, 32'h0040_0010);

        // Jump beats branch
        fetch_and_hold(32'h0810_0000);
        bus.jump_in         = 1'b1;
        bus.target_in       = 26'h010_0000;
        bus.branch_taken_in = 1'b1;
        bus.imm16_in        = 16'h0040;
        step();
        clear_redirects();
        chk("jump_pc", bus.pc_out, 32'h0040_0000);

        // JR beats jump
        fetch_and_hold(32'h0120_0008);
        bus.jr_in      = 1'b1;
        bus.jr_addr_in = 32'h0040_0107;
        bus.jump_in    = 1'b1;
        bus.target_in  = 26'h000_1234;
        step();
        clear_redirects();
        chk("jr_pc", bus.pc_out, 32'h0040_0104);

        // Move to top of address space, then wrap sequentially
        fetch_and_hold(32'h0120_0008);
        bus.jr_in      = 1'b1;
        bus.jr_addr_in = 32'hFFFF_FFFE;
        step();
        clear_redirects();
        chk("top_pc", bus.pc_out, 32'hFFFF_FFFC);
        fetch_and_hold(32'h0000_0000);
        step();
        chk("wrap_pc", bus.pc_out, 32'h0000_0000);

        // Reset during REQ with simultaneous ack
        chk("pre_rst_req", {31'h0, bus.mem_req_out}, 32'h1);
        reset           = 1'b1;
        bus.mem_ack_in  = 1'b1;
        bus.mem_data_in = 32'hCAFE_F00D;
        step();
        chk("rrst_valid", {31'h0, bus.valid_out}, 32'h0);
        chk("rrst_pc",    bus.pc_out, 32'h0040_0000);
        chk("rrst_instr", bus.instruction_out, 32'h0);
        chk("rrst_req",   {31'h0, bus.mem_req_out}, 32'h0);
        // Ack in IDLE is ignored
        reset = 1'b0;
        step();
        chk("idle_ack_instr", bus.instruction_out, 32'h0);
        chk("idle_ack_valid", {31'h0, bus.valid_out}, 32'h0);
        chk("idle_ack_req",   {31'h0, bus.mem_req_out}, 32'h1);
        step();
        bus.mem_ack_in = 1'b0;
        chk("refetch_instr", bus.instruction_out, 32'hCAFE_F00D);
        chk("refetch_pc",    bus.pc_out, 32'h0040_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
